gr_wb_arbiter: RTL and testbench
================================

// Module: gr_wb_arbiter
// PURPOSE
//  Shares the single general-register (GR) write port among NREQ writeback requesters (ALU, LSU, MUL/DIV).
//  - Arbitration: round-robin, valid/ready per requester.
//  - Output: the winner is registered into a one-stage write latch that drives the GR file's we/waddr/wdata.
//  - Position: between the execute/memory writeback sources and the GR file.
// PARAMETERS
//  NREQ   3   number of writeback requesters (2..8)
//  AW     5   GR address width
//  DW     32  GR data width
// PORTS
//  clk        in   1        single clock; all state updates on posedge
//  rst_n      in   1        reset, asynchronous assert, active-low
//  wb_hold    in   1        1 = grant nothing this cycle (pipeline freeze)
//  req_valid  in   NREQ     requester i has a write pending
//  req_ready  out  NREQ     one-hot grant; transfer when valid[i]&ready[i]
//  req_addr   in   NREQ*AW  flattened, requester i at [i*AW +: AW]
//  req_data   in   NREQ*DW  flattened, requester i at [i*DW +: DW]
//  gr_we      out  1        to GR file write enable (registered)
//  gr_waddr   out  AW       to GR file write address (registered)
//  gr_wdata   out  DW       to GR file write data (registered)
//  wb_busy    out  1        registered: 1 if any req_valid was high last cycle and not granted
// BEHAVIOUR
//  Reset (rst_n=0, async): gr_we=0, gr_waddr=0, gr_wdata=0, rr_ptr=0, wb_busy=0.
//    req_ready is combinational and reads 0 while in reset.
//  Grant (combinational):
//    - If wb_hold=1 or no valid, req_ready=0.
//    - Otherwise scan from rr_ptr upward, modulo NREQ; the first valid i gets req_ready[i]=1. At most one bit is set.
//  Pointer: on a transfer by i, rr_ptr <= (i+1)%NREQ (wrap NREQ-1 -> 0). Unchanged when there is no transfer.
//  Write latch: a transfer at edge t appears on gr_we/waddr/wdata for cycle t+1, so latency is exactly 1.
//    - No transfer: gr_we <= 0; gr_waddr and gr_wdata hold their values.
//  r0 writes: accepted (ready=1, pointer advances) but gr_we <= 0, because register 0 is hardwired to zero.
//  Same-address writes from two requesters in one cycle: serialized in grant order; the later grant wins the register.
//  Requester rules:
//    - Must hold valid/addr/data stable until ready.
//    - ready never depends on the requester's own data.
//    - A requester with no valid never receives ready.
//  Throughput: 1 write/cycle. Any requester waits at most NREQ-1 grants.
//  wb_hold mid-operation: already-latched write still commits next cycle; no new grant while held.
//  Reset mid-operation: a pending latch write is discarded (gr_we=0 immediately).
// CONFIGURATION
//  GR_WB_FWD_EN defined adds read-side forwarding of the in-flight latched write:
//    - Ports: fwd_raddr1/2/3 in AW; fwd_hit[2:0] out; fwd_data out DW.
//    - fwd_hit[k] = gr_we & (gr_waddr==fwd_raddrk) & (fwd_raddrk!=0). Combinational.
//    - fwd_data = gr_wdata.
//    - Purpose: closes the same-cycle write/read hazard, because the GR file reads are not bypassed.
//  GR_WB_FWD_EN undefined: these ports are absent; readers see the GR file only.
// STRUCTURE
//  Shared defines (defs.v): `GR_AW=5, `GR_DW=32, `GR_ZERO=5'h0. Parameters default to these.
//  Sub-module rr_arbiter:
//    - Inputs: req[NREQ], ptr, en. Outputs: one-hot gnt, encoded gnt_idx.
//    - Purely combinational.
//  The top holds rr_ptr, the write latch, wb_busy and optional forwarding.
// TESTING
//  1. Reset: rst_n=0 mid-cycle with a latch pending -> gr_we=0 at once; after release, ready=0 and all outputs 0.
//  2. Single write: req0 valid, addr=5, data=32'hDEAD_BEEF -> ready0=1 at cycle t; next cycle gr_we=1, gr_waddr=5, gr_wdata=DEADBEEF.
//  3. All three valid for 6 cycles -> grant order 0,1,2,0,1,2 and gr_we=1 every cycle from t+1.
//  4. req1 addr=0 -> ready1=1, rr_ptr -> 2, gr_we=0 next cycle.
//  5. wb_hold=1 for 3 cycles with req2 valid -> ready=0 and wb_busy=1. Release -> req2 granted and written one cycle later.
//  6. (GR_WB_FWD_EN) latch holds addr=7, data=32'h1234 and fwd_raddr2=7 -> fwd_hit=3'b010, fwd_data=32'h1234. fwd_raddr=0 -> no hit.

Source files
------------

// File: rtl/gr_wb_arbiter_pkg.sv
// Shared constants and helpers for the GR writeback arbiter.
package gr_wb_arbiter_pkg;

  // Default GR file geometry.
  localparam int unsigned GrAw = 5;
  localparam int unsigned GrDw = 32;

  // Conventional requester slot assignment in the default three-source build.
  typedef enum logic [1:0] {
    ReqAlu    = 2'd0,
    ReqLsu    = 2'd1,
    ReqMulDiv = 2'd2
  } wb_src_e;

  // Round-robin successor of idx among n slots.
  function automatic int unsigned rr_next(input int unsigned idx, input int unsigned n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/gr_wb_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first request at or above ptr (mod NREQ) wins.
module gr_wb_arbiter_rr_arbiter #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   gnt_idx
);

  // Scan NREQ slots starting at ptr; at most one grant bit is ever set.
  always_comb begin
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = (32'(ptr) + 32'(k)) % NREQ;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = PW'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gr_wb_arbiter.sv
// GR write-port arbiter: round-robin among NREQ writeback sources, winner registered into a
// one-stage write latch feeding the GR file. Writes to r0 are accepted but never enabled.
// Optional read-side forwarding of the latched write is built when GR_WB_FWD_EN is defined.
module gr_wb_arbiter
  import gr_wb_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 3,
  parameter int unsigned AW   = GrAw,
  parameter int unsigned DW   = GrDw
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wb_hold,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic              gr_we,
  output logic [AW-1:0]     gr_waddr,
  output logic [DW-1:0]     gr_wdata,
  output logic              wb_busy
`ifdef GR_WB_FWD_EN
  ,
  input  logic [AW-1:0]     fwd_raddr1,
  input  logic [AW-1:0]     fwd_raddr2,
  input  logic [AW-1:0]     fwd_raddr3,
  output logic [2:0]        fwd_hit,
  output logic [DW-1:0]     fwd_data
`endif
);

  localparam int unsigned PW = $clog2(NREQ);

  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic            gr_we_q, gr_we_d;
  logic [AW-1:0]   gr_waddr_q, gr_waddr_d;
  logic [DW-1:0]   gr_wdata_q, gr_wdata_d;
  logic            wb_busy_q, wb_busy_d;

  logic            grant_en;
  logic            xfer;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic [AW-1:0]   win_addr;
  logic [DW-1:0]   win_data;

  // Reset gating keeps ready low while rst_n is asserted, independent of the registers.
  assign grant_en = rst_n & ~wb_hold;

  gr_wb_arbiter_rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr_q),
    .en      (grant_en),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign win_addr  = req_addr[int'(gnt_idx)*AW +: AW];
  assign win_data  = req_data[int'(gnt_idx)*DW +: DW];

  // Next-state: pointer advance, write latch load and stall indication.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    gr_we_d    = 1'b0;
    gr_waddr_d = gr_waddr_q;
    gr_wdata_d = gr_wdata_q;
    wb_busy_d  = |(req_valid & ~gnt);
    if (xfer) begin
      rr_ptr_d   = PW'(rr_next(32'(gnt_idx), NREQ));
      // r0 is hardwired to zero: consume the request but suppress the write.
      gr_we_d    = (win_addr != '0);
      gr_waddr_d = win_addr;
      gr_wdata_d = win_data;
    end
  end

  // State registers; async reset also discards any pending latched write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= '0;
      gr_we_q    <= 1'b0;
      gr_waddr_q <= '0;
      gr_wdata_q <= '0;
      wb_busy_q  <= 1'b0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      gr_we_q    <= gr_we_d;
      gr_waddr_q <= gr_waddr_d;
      gr_wdata_q <= gr_wdata_d;
      wb_busy_q  <= wb_busy_d;
    end
  end

  assign gr_we    = gr_we_q;
  assign gr_waddr = gr_waddr_q;
  assign gr_wdata = gr_wdata_q;
  assign wb_busy  = wb_busy_q;

`ifdef GR_WB_FWD_EN
  // Bypass the in-flight write to readers; GR file reads are not internally bypassed.
  always_comb begin
    fwd_hit    = '0;
    fwd_hit[0] = gr_we_q & (gr_waddr_q == fwd_raddr1) & (fwd_raddr1 != '0);
    fwd_hit[1] = gr_we_q & (gr_waddr_q == fwd_raddr2) & (fwd_raddr2 != '0);
    fwd_hit[2] = gr_we_q & (gr_waddr_q == fwd_raddr3) & (fwd_raddr3 != '0);
  end

  assign fwd_data = gr_wdata_q;
`endif

endmodule

// File: tb/tb_gr_wb_arbiter.sv
// Directed bench for gr_wb_arbiter with a write-latch scoreboard.
module tb_gr_wb_arbiter;

  localparam int unsigned NREQ = 3;
  localparam int unsigned AW   = 5;
  localparam int unsigned DW   = 32;

  logic              clk;
  logic              rst_n;
  logic              wb_hold;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic              gr_we;
  logic [AW-1:0]     gr_waddr;
  logic [DW-1:0]     gr_wdata;
  logic              wb_busy;
`ifdef GR_WB_FWD_EN
  logic [AW-1:0]     fwd_raddr1, fwd_raddr2, fwd_raddr3;
  logic [2:0]        fwd_hit;
  logic [DW-1:0]     fwd_data;
`endif

  gr_wb_arbiter #(
    .NREQ (NREQ),
    .AW   (AW),
    .DW   (DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb_hold   (wb_hold),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .gr_we     (gr_we),
    .gr_waddr  (gr_waddr),
    .gr_wdata  (gr_wdata),
    .wb_busy   (wb_busy)
`ifdef GR_WB_FWD_EN
    ,
    .fwd_raddr1 (fwd_raddr1),
    .fwd_raddr2 (fwd_raddr2),
    .fwd_raddr3 (fwd_raddr3),
    .fwd_hit    (fwd_hit),
    .fwd_data   (fwd_data)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic          we;
    logic          chk_ad;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic          busy;
  } exp_t;

  exp_t          sb[$];
  logic [AW-1:0] ta [NREQ];
  logic [DW-1:0] td [NREQ];
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic          m_known;
  int            total;
  int            bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, check ready, push the expected latch, check it after posedge.
  task automatic cycle(input logic [NREQ-1:0] v, input logic h, input logic [NREQ-1:0] exp_rdy);
    exp_t e;
    int   idx;
    req_addr  = {ta[2], ta[1], ta[0]};
    req_data  = {td[2], td[1], td[0]};
    req_valid = v;
    wb_hold   = h;
    #1;
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    e.busy = |(v & ~exp_rdy);
    e.we   = 1'b0;
    if (exp_rdy != '0) begin
      idx = 0;
      for (int i = 0; i < int'(NREQ); i++) if (exp_rdy[i]) idx = i;
      if (ta[idx] == '0) begin
        m_known = 1'b0;
      end else begin
        e.we    = 1'b1;
        m_known = 1'b1;
        m_addr  = ta[idx];
        m_data  = td[idx];
      end
    end
    e.chk_ad = m_known;
    e.addr   = m_addr;
    e.data   = m_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("gr_we", 32'(gr_we), 32'(e.we));
    chk("wb_busy", 32'(wb_busy), 32'(e.busy));
    if (e.chk_ad) begin
      chk("gr_waddr", 32'(gr_waddr), 32'(e.addr));
      chk("gr_wdata", gr_wdata, e.data);
    end
    @(negedge clk);
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    rst_n     = 1'b1;
    wb_hold   = 1'b0;
    req_valid = '0;
    req_addr  = '0;
    req_data  = '0;
    m_addr    = '0;
    m_data    = '0;
    m_known   = 1'b1;
    for (int i = 0; i < int'(NREQ); i++) begin
      ta[i] = '0;
      td[i] = '0;
    end
`ifdef GR_WB_FWD_EN
    fwd_raddr1 = '0;
    fwd_raddr2 = '0;
    fwd_raddr3 = '0;
`endif

    // Reset state.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_we", 32'(gr_we), 32'h0);
    chk("rst_waddr", 32'(gr_waddr), 32'h0);
    chk("rst_wdata", gr_wdata, 32'h0);
    chk("rst_busy", 32'(wb_busy), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Single write from requester 0.
    ta[0] = 5'd5;
    td[0] = 32'hDEAD_BEEF;
    cycle(3'b001, 1'b0, 3'b001);

    // Async reset mid-cycle with that write still in the latch.
    req_valid = 3'b001;
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_we", 32'(gr_we), 32'h0);
    chk("midrst_waddr", 32'(gr_waddr), 32'h0);
    chk("midrst_wdata", gr_wdata, 32'h0);
    chk("midrst_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = '0;
    rst_n     = 1'b1;
    m_addr    = '0;
    m_data    = '0;
    m_known   = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'h0);
    chk("post_rst_we", 32'(gr_we), 32'h0);
    chk("post_rst_busy", 32'(wb_busy), 32'h0);
    @(negedge clk);

    // Idle cycle: pointer must stay at 0.
    cycle(3'b000, 1'b0, 3'b000);

    // All three valid: strict rotation 0,1,2,0,1,2 with a write every cycle.
    ta[0] = 5'd1;  td[0] = 32'hA000_0000;
    ta[1] = 5'd2;  td[1] = 32'hA111_1111;
    ta[2] = 5'd3;  td[2] = 32'hA222_2222;
    cycle(3'b111, 1'b0, 3'b001);
    cycle(3'b111, 1'b0, 3'b010);
    cycle(3'b111, 1'b0, 3'b100);
    cycle(3'b111, 1'b0, 3'b001);
    cycle(3'b111, 1'b0, 3'b010);
    cycle(3'b111, 1'b0, 3'b100);

    // r0 write from requester 1: granted, no write enable, pointer moves to 2.
    ta[1] = 5'd0;
    cycle(3'b010, 1'b0, 3'b010);
    ta[1] = 5'd2;
    cycle(3'b111, 1'b0, 3'b100);

    // Freeze with requester 2 waiting, then release.
    ta[2] = 5'd7;
    td[2] = 32'h0000_1234;
    cycle(3'b100, 1'b1, 3'b000);
    cycle(3'b100, 1'b1, 3'b000);
    cycle(3'b100, 1'b1, 3'b000);
    cycle(3'b100, 1'b0, 3'b100);

`ifdef GR_WB_FWD_EN
    // Latch now holds addr 7 / data 0x1234.
    fwd_raddr1 = 5'd3;
    fwd_raddr2 = 5'd7;
    fwd_raddr3 = 5'd0;
    #1;
    chk("fwd_hit_r2", 32'(fwd_hit), 32'h2);
    chk("fwd_data", fwd_data, 32'h0000_1234);
    fwd_raddr1 = 5'd7;
    fwd_raddr2 = 5'd0;
    fwd_raddr3 = 5'd7;
    #1;
    chk("fwd_hit_r13", 32'(fwd_hit), 32'h5);
    fwd_raddr1 = 5'd0;
    fwd_raddr3 = 5'd0;
    #1;
    chk("fwd_hit_zero", 32'(fwd_hit), 32'h0);
    @(negedge clk);
`endif

    // Drain: no requests, write enable drops.
    cycle(3'b000, 1'b0, 3'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
